// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, x/y counters, registered syncs and active flag.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clkin,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [15:0] xcoord,
  output logic [15:0] ycoord,
  output logic        active,
  output logic        Hsync,
  output logic        Vsync,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [4:0]  div_cnt;
  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        line_end;
  logic        frame_end;

  always_comb begin
    line_end  = (xcoord == H_LAST);
    frame_end = (ycoord == V_LAST);
    x_next    = xcoord;
    y_next    = ycoord;
    if (pix_en) begin
      if (line_end) begin
        x_next = '0;
        y_next = frame_end ? '0 : ycoord + 16'd1;
      end else begin
        x_next = xcoord + 16'd1;
      end
    end
  end

  assign frame_start = pix_en && line_end && frame_end;

  // Syncs and active are derived from the next-state counters so they
  // switch on the same edge as the coordinates while staying registered.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
      xcoord  <= '0;
      ycoord  <= '0;
      active  <= 1'b1;
      Hsync   <= 1'b1;
      Vsync   <= 1'b1;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 5'd1;
      pix_en  <= (div_cnt == DIV_LAST);
      xcoord  <= x_next;
      ycoord  <= y_next;
      active  <= (x_next < H_ACT) && (y_next < V_ACT);
      Hsync   <= !((x_next >= HS_BEG) && (x_next <= HS_END));
      Vsync   <= !((y_next >= VS_BEG) && (y_next <= VS_END));
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset scoreboard bench for vga_timing_gen: a default-parameter instance and a
// reduced-parameter instance are checked every cycle against a closed-form raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_en;
    logic [15:0] x;
    logic [15:0] y;
    logic        active;
    logic        hs;
    logic        vs;
    logic        fs;
  } obs_t;

  typedef struct packed {
    obs_t        d;
    obs_t        s;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obs_t act_d, act_s;
  logic [15:0] fc_d, fc_s;

  vga_timing_gen dut_d (
    .clkin(clk), .rst_n(rst_n), .pix_en(act_d.pix_en), .xcoord(act_d.x), .ycoord(act_d.y),
    .active(act_d.active), .Hsync(act_d.hs), .Vsync(act_d.vs), .frame_start(act_d.fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clkin(clk), .rst_n(rst_n), .pix_en(act_s.pix_en), .xcoord(act_s.x), .ycoord(act_s.y),
    .active(act_s.active), .Hsync(act_s.hs), .Vsync(act_s.vs), .frame_start(act_s.fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_d = '0;
  assign fc_s = '0;
`endif

  // k = rising edges seen with reset released; the raster position follows directly from it.
  function automatic obs_t model(input int unsigned k, input int unsigned d,
                                 input int unsigned ha, input int unsigned hf,
                                 input int unsigned hs, input int unsigned hb,
                                 input int unsigned va, input int unsigned vf,
                                 input int unsigned vs, input int unsigned vb);
    obs_t o;
    int unsigned ht, vt, steps, p, x, y;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    o.pix_en = (k >= 1) && (k % d == 0);
    steps = (k == 0) ? 0 : (k - 1) / d;
    p = steps % (ht * vt);
    x = p % ht;
    y = p / ht;
    o.x = 16'(x);
    o.y = 16'(y);
    o.active = (x < ha) && (y < va);
    o.hs = !((x >= ha + hf) && (x < ha + hf + hs));
    o.vs = !((y >= va + vf) && (y < va + vf + vs));
    o.fs = o.pix_en && (x == ht - 1) && (y == vt - 1);
    return o;
  endfunction

  function automatic logic [15:0] frames(input int unsigned k);
    int unsigned steps;
    steps = (k == 0) ? 0 : (k - 1) / 2;
    return 16'((steps / (15 * 12)) % 65536);
  endfunction

  exp_t exp_q[$];
  int unsigned k = 0;
  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  task automatic step(input logic new_rst);
    exp_t e;
    @(posedge clk);
    if (rst_n) k++;
    #2;
    rst_n = new_rst;
    if (!rst_n) k = 0;
    e.d  = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    e.s  = model(k, 2, 8, 2, 3, 2, 6, 1, 2, 3);
    e.fc = frames(k);
    exp_q.push_back(e);
  endtask

  initial begin
    int unsigned hold, run;
    rst_n = 1'b0;
    repeat (3) step(1'b0);
    repeat (12000) step(1'b1);
    for (int seg = 0; seg < 6; seg++) begin
      hold = $urandom_range(1, 4);
      run  = $urandom_range(300, 5000);
      repeat (hold) step(1'b0);
      repeat (run) step(1'b1);
    end
    @(posedge clk);
    @(posedge clk);
    done = 1'b1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (act_d !== e.d) begin
          miscompares++;
          $display("FAIL default t=%0t: got pix_en=%b x=%0d y=%0d act=%b hs=%b vs=%b fs=%b, want pix_en=%b x=%0d y=%0d act=%b hs=%b vs=%b fs=%b",
                   $time, act_d.pix_en, act_d.x, act_d.y, act_d.active, act_d.hs, act_d.vs, act_d.fs,
                   e.d.pix_en, e.d.x, e.d.y, e.d.active, e.d.hs, e.d.vs, e.d.fs);
        end
        vectors++;
        if (act_s !== e.s) begin
          miscompares++;
          $display("FAIL small t=%0t: got pix_en=%b x=%0d y=%0d act=%b hs=%b vs=%b fs=%b, want pix_en=%b x=%0d y=%0d act=%b hs=%b vs=%b fs=%b",
                   $time, act_s.pix_en, act_s.x, act_s.y, act_s.active, act_s.hs, act_s.vs, act_s.fs,
                   e.s.pix_en, e.s.x, e.s.y, e.s.active, e.s.hs, e.s.vs, e.s.fs);
        end
`ifdef VGA_FRAME_CNT_EN
        vectors++;
        if (fc_s !== e.fc) begin
          miscompares++;
          $display("FAIL frame_cnt t=%0t: got %0d, want %0d", $time, fc_s, e.fc);
        end
`endif
      end
    end
  end

endmodule
